uart_line_echo: RTL

Host-side line responder for the UART. Sits behind `uart_top`'s FIFO ports: pops received bytes from the RX FIFO and buffers them until a line terminator arrives. It then writes the line back, optionally upper-cased, into the TX FIFO. Lines with receive errors or overflow are answered with a short status line instead.

---
 rtl/uart_line_echo_if.sv | 31 +++
 rtl/uart_line_echo.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_line_echo_if.sv
// ---------------------------------------------------------------------------
// uart_line_echo_if
// FIFO-side handshake bundle between uart_line_echo and the UART FIFOs.
//   rx_empty  RX FIFO empty
//   rx_data   RX FIFO head byte (first-word-fall-through)
//   rx_err    parity/frame error qualifier for the head byte
//   rx_rd     pop RX FIFO head this cycle
//   tx_full   TX FIFO full
//   tx_wr     push tx_data this cycle
//   tx_data   byte to TX FIFO
// master: the line responder; slave: the FIFO side.
// ---------------------------------------------------------------------------
interface uart_line_echo_if;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_rd;
    logic       tx_full;
    logic       tx_wr;
    logic [7:0] tx_data;

    modport master (
        input  rx_empty, rx_data, rx_err, tx_full,
        output rx_rd, tx_wr, tx_data
    );

    modport slave (
        output rx_empty, rx_data, rx_err, tx_full,
        input  rx_rd, tx_wr, tx_data
    );
endinterface

// File: rtl/uart_line_echo.sv
// ---------------------------------------------------------------------------
// uart_line_echo
// Collects bytes from the RX FIFO until TERM, then writes the line back
// (optionally upper-cased) into the TX FIFO. Lines that overflowed the buffer
// are answered with "!"+TERM, lines with receive errors with "?"+TERM.
//   clk         system clock, rising edge
//   reset       synchronous, active-low
//   fifo        RX/TX FIFO handshake (master side)
//   busy        high while sending a response
//   line_count  lines answered (wraps)
//   bad_count   lines answered with a status line (wraps)
// ---------------------------------------------------------------------------
module uart_line_echo #(
    parameter int unsigned MAX_LINE = 64,
    parameter logic [7:0]  TERM     = 8'h0A,
    parameter bit          UPPER    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    uart_line_echo_if.master fifo,
    output logic             busy,
    output logic [15:0]      line_count,
    output logic [15:0]      bad_count
);
    localparam int unsigned AW = $clog2(MAX_LINE);
    localparam int unsigned LW = AW + 1;   // len/idx span 0..MAX_LINE

    typedef enum logic {COLLECT, SEND} state_e;

    state_e      state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic        bad_err_q, bad_err_d;
    logic        bad_ovf_q, bad_ovf_d;
    logic [15:0] line_count_q, line_count_d;
    logic [15:0] bad_count_q, bad_count_d;

    logic [7:0]  line_buf_q [MAX_LINE];
    logic        buf_we;

    logic        status;
    logic        last;
    logic [7:0]  seq_byte;

    function automatic logic [7:0] case_map(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (UPPER && (b >= 8'h61) && (b <= 8'h7A)) begin
            r = b - 8'h20;
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        bad_err_d    = bad_err_q;
        bad_ovf_d    = bad_ovf_q;
        line_count_d = line_count_q;
        bad_count_d  = bad_count_q;
        buf_we       = 1'b0;
        fifo.rx_rd   = 1'b0;
        fifo.tx_wr   = 1'b0;
        fifo.tx_data = '0;

        // Response byte at position idx; status lines are always two bytes,
        // clean lines are len bytes followed by TERM.
        status = bad_ovf_q | bad_err_q;
        if (status) begin
            seq_byte = (idx_q == '0) ? (bad_ovf_q ? 8'h21 : 8'h3F) : TERM;
            last     = (idx_q == LW'(1));
        end else begin
            seq_byte = (idx_q < len_q) ? case_map(line_buf_q[idx_q[AW-1:0]]) : TERM;
            last     = (idx_q == len_q);
        end

        case (state_q)
            COLLECT: begin
                fifo.rx_rd = reset & ~fifo.rx_empty;
                if (fifo.rx_rd) begin
                    if (fifo.rx_err) begin
                        bad_err_d = 1'b1;
                    end
                    if (fifo.rx_data == TERM) begin
                        state_d = SEND;
                        idx_d   = '0;
                    end else if (len_q < LW'(MAX_LINE)) begin
                        buf_we = 1'b1;
                        len_d  = len_q + LW'(1);
                    end else begin
                        bad_ovf_d = 1'b1;
                    end
                end
            end
            SEND: begin
                fifo.tx_data = seq_byte;
                fifo.tx_wr   = reset & ~fifo.tx_full;
                if (fifo.tx_wr) begin
                    if (last) begin
                        line_count_d = line_count_q + 16'd1;
                        if (status) begin
                            bad_count_d = bad_count_q + 16'd1;
                        end
                        len_d     = '0;
                        bad_err_d = 1'b0;
                        bad_ovf_d = 1'b0;
                        state_d   = COLLECT;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= COLLECT;
            len_q        <= '0;
            idx_q        <= '0;
            bad_err_q    <= 1'b0;
            bad_ovf_q    <= 1'b0;
            line_count_q <= '0;
            bad_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            bad_err_q    <= bad_err_d;
            bad_ovf_q    <= bad_ovf_d;
            line_count_q <= line_count_d;
            bad_count_q  <= bad_count_d;
        end
    end

    // Line storage is deliberately not reset; len bounds what is valid.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf_q[len_q[AW-1:0]] <= fifo.rx_data;
        end
    end

    assign busy       = (state_q == SEND);
    assign line_count = line_count_q;
    assign bad_count  = bad_count_q;
endmodule
